// File: rtl/bfloat16_add_sequencer.sv
// bfloat16_add_sequencer: queues bfloat16 operand pairs, sequences them through an
// external handshaking adder, and returns each sum with classification flags.
module bfloat16_add_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic [15:0] adder_a,
   output logic [15:0] adder_b,
   input  logic [15:0] adder_sum,
   input  logic        adder_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sum,
   output logic [3:0]  out_flags,
   output logic [7:0]  op_count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   typedef enum logic [2:0] {IDLE, ISSUE, RUN, WAIT_DONE, EMIT} state_t;
   state_t        state;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] timer;
   logic [31:0]   head;
   logic          ready_q, push, pop, rise, busy, tmo;
   function automatic logic [3:0] flags_of(input logic [15:0] s);
      return {1'b0, s[14:7] == 8'hFF && s[6:0] != 7'd0, s[14:7] == 8'hFF && s[6:0] == 7'd0,
              s[14:7] == 8'h00 && s[6:0] == 7'd0};
   endfunction
   always_comb begin
      in_ready = count < CW'(DEPTH);
      push     = in_valid && in_ready;
      rise     = adder_ready && !ready_q;
      busy     = state == ISSUE || state == RUN || state == WAIT_DONE;
      tmo      = busy && timer == TW'(TIMEOUT - 1);
      pop      = tmo || (state == WAIT_DONE && rise);
      head     = mem[rd_ptr];
   end
   always_ff @(posedge clock)
      if (push) mem[wr_ptr] <= {in_a, in_b};
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   // The head pair stays in the FIFO until its result is captured, so count includes it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         adder_a   <= '0;
         adder_b   <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_flags <= '0;
         op_count  <= '0;
         ready_q   <= 1'b0;
         timer     <= '0;
      end else begin
         ready_q <= adder_ready;
         if (busy) timer <= timer + 1'b1;
         case (state)
            IDLE:
               if (count != '0) begin
                  adder_a <= head[31:16];
                  adder_b <= head[15:0];
                  timer   <= '0;
                  state   <= ISSUE;
               end
            ISSUE, RUN, WAIT_DONE:
               if (tmo) begin
                  out_sum   <= 16'h7FC1;
                  out_flags <= 4'b1100;
                  out_valid <= 1'b1;
                  state     <= EMIT;
               end else if (state == ISSUE && rise) begin
                  timer <= '0;
                  state <= RUN;
               end else if (state == RUN && !adder_ready) begin
                  timer <= '0;
                  state <= WAIT_DONE;
               end else if (state == WAIT_DONE && rise) begin
                  out_sum   <= adder_sum;
                  out_flags <= flags_of(adder_sum);
                  out_valid <= 1'b1;
                  state     <= EMIT;
               end
            EMIT:
               if (out_ready) begin
                  out_valid <= 1'b0;
                  op_count  <= op_count + 8'd1;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
